// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
//
// Shared definitions for the MEM-stage data-memory responder:
//   - state_t      : responder FSM states (IDLE/REQ/WAIT/DONE)
//   - OPCODE_LOAD  : pipeline opcode of a load instruction
//   - OPCODE_STORE : pipeline opcode of a store instruction
//   - WORD_W       : data word width of the memory interface
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int WORD_W = 32;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : dmem_responder_pkg

// File: rtl/dmem_cache_array.sv
// ---------------------------------------------------------------------------
// dmem_cache_array
//
// Storage for a direct-mapped cache with one-word lines: a valid bit, a tag
// and a data word per line.
//
// Ports:
//   clk      in   clock
//   rstn     in   synchronous active-low reset (clears every valid bit)
//   rd_idx   in   line index for the combinational read port
//   rd_valid out  valid bit of line rd_idx
//   rd_tag   out  tag of line rd_idx
//   rd_data  out  data word of line rd_idx
//   wr_en    in   write strobe, sampled on the rising clock edge
//   wr_idx   in   line index to write
//   wr_tag   in   tag to store
//   wr_data  in   data word to store
// ---------------------------------------------------------------------------
module dmem_cache_array
    import dmem_responder_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_data
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [WORD_W-1:0] data_q [DEPTH];

    // Only the valid bits need a reset; tag/data of an invalid line are
    // never looked at.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule : dmem_cache_array

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// MEM-stage data-memory responder. Loads that hit the direct-mapped,
// write-through, one-word-line cache complete with zero stall. Load misses
// and all stores go to a variable-latency backing memory; the pipeline is
// frozen (data_ready_mem=0) until the transaction completes.
//
// Ports:
//   clk                    in   clock
//   rstn                   in   synchronous active-low reset
//   memread_mem            in   load in MEM stage
//   memwrite_mem           in   store in MEM stage (wins over memread_mem)
//   alu_result_mem         in   byte address, bits [1:0] ignored
//   write_data_memory_mem  in   store data
//   data_from_memory_mem   out  load data, valid with data_ready_mem=1
//   data_ready_mem         out  1 = pipeline may advance this edge
//   mem_req_valid          out  backing request valid (registered)
//   mem_req_ready          in   backing accepts request
//   mem_req_we             out  1 = write request
//   mem_req_addr           out  word-aligned request address
//   mem_req_wdata          out  write data
//   mem_resp_valid         in   read data / write ack, one pulse per request
//   mem_resp_rdata         in   read data
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              memread_mem,
    input  logic              memwrite_mem,
    input  logic [ADDR_W-1:0] alu_result_mem,
    input  logic [WORD_W-1:0] write_data_memory_mem,
    output logic [WORD_W-1:0] data_from_memory_mem,
    output logic              data_ready_mem,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [WORD_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [WORD_W-1:0] mem_resp_rdata
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    state_t            state;
    logic [WORD_W-1:0] data_buf;

    logic [IDX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]  cur_tag;
    logic              is_store;
    logic              is_load;
    logic              load_hit;
    logic              need_access;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [WORD_W-1:0] rd_data;

    logic              fill_en;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [WORD_W-1:0] fill_data;

    // Byte-offset bits never select anything: the word is chosen by [31:2].
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{alu_result_mem[1:0], mem_req_addr[1:0]};

    assign cur_idx = alu_result_mem[IDX_W+1:2];
    assign cur_tag = alu_result_mem[ADDR_W-1:IDX_W+2];

    assign is_store    = memwrite_mem;
    assign is_load     = memread_mem && !memwrite_mem;
    assign load_hit    = is_load && rd_valid && (rd_tag == cur_tag);
    assign need_access = is_store || (is_load && !load_hit);

    dmem_cache_array #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_cache (
        .clk      (clk),
        .rstn     (rstn),
        .rd_idx   (cur_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_en),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_data  (fill_data)
    );

    // The line is updated from the registered request, so the fill does not
    // depend on the pipeline keeping its inputs stable. A store allocates the
    // line without a fetch, which is safe because a line is a single word.
    assign fill_en   = (state == WAIT) && mem_resp_valid;
    assign fill_idx  = mem_req_addr[IDX_W+1:2];
    assign fill_tag  = mem_req_addr[ADDR_W-1:IDX_W+2];
    assign fill_data = mem_req_we ? mem_req_wdata : mem_resp_rdata;

    // Hits must answer in the same cycle, so the stall and the load data are
    // combinational in IDLE; in DONE they come from the data buffer.
    always_comb begin
        data_ready_mem       = 1'b0;
        data_from_memory_mem = '0;
        case (state)
            IDLE: begin
                data_ready_mem = !need_access;
                if (load_hit) begin
                    data_from_memory_mem = rd_data;
                end
            end
            DONE: begin
                data_ready_mem       = 1'b1;
                data_from_memory_mem = data_buf;
            end
            default: begin
                data_ready_mem = 1'b0;
            end
        endcase
    end

    // Transaction FSM. A response arriving outside WAIT is dropped, which is
    // what makes a reset in the middle of a transaction safe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            data_buf      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (need_access) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= is_store;
                        mem_req_addr  <= {alu_result_mem[ADDR_W-1:2], 2'b00};
                        mem_req_wdata <= write_data_memory_mem;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (!mem_req_we) begin
                            data_buf <= mem_resp_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed testbench for dmem_responder with a behavioural backing memory
// whose request-accept delay and response delay are adjustable per test.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk;
    logic        rstn;
    logic        memread_mem;
    logic        memwrite_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] write_data_memory_mem;
    logic [31:0] data_from_memory_mem;
    logic        data_ready_mem;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int check_count = 0;
    int error_count = 0;

    // Backing memory model state
    logic [31:0] backing [logic [31:0]];
    int          ready_delay = 0;
    int          resp_delay  = 0;
    int          stall_left  = 0;
    int          resp_wait   = 0;
    logic        resp_due    = 1'b0;
    logic [31:0] resp_data   = '0;
    int          req_count   = 0;
    logic [31:0] last_req_addr  = '0;
    logic        last_req_we    = 1'b0;
    logic [31:0] last_req_wdata = '0;
    logic        tracking       = 1'b0;
    logic [31:0] first_addr     = '0;
    logic        first_we       = 1'b0;
    logic [31:0] first_wdata    = '0;
    logic        req_unstable   = 1'b0;

    dmem_responder #(
        .IDX_W  (6),
        .ADDR_W (32)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .memread_mem           (memread_mem),
        .memwrite_mem          (memwrite_mem),
        .alu_result_mem        (alu_result_mem),
        .write_data_memory_mem (write_data_memory_mem),
        .data_from_memory_mem  (data_from_memory_mem),
        .data_ready_mem        (data_ready_mem),
        .mem_req_valid         (mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_we            (mem_req_we),
        .mem_req_addr          (mem_req_addr),
        .mem_req_wdata         (mem_req_wdata),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_rdata        (mem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural backing memory: drives ready/response at the falling edge so
    // they are stable across the next rising edge. Responses come no earlier
    // than one cycle after acceptance.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (resp_due) begin
                if (resp_wait > 0) begin
                    resp_wait--;
                end else begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = resp_data;
                    resp_due       = 1'b0;
                end
            end else if (mem_req_valid) begin
                if (!tracking) begin
                    tracking    = 1'b1;
                    first_addr  = mem_req_addr;
                    first_we    = mem_req_we;
                    first_wdata = mem_req_wdata;
                end else if (mem_req_addr != first_addr || mem_req_we != first_we ||
                             mem_req_wdata != first_wdata) begin
                    req_unstable = 1'b1;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_ready  = 1'b1;
                    tracking       = 1'b0;
                    req_count++;
                    last_req_addr  = mem_req_addr;
                    last_req_we    = mem_req_we;
                    last_req_wdata = mem_req_wdata;
                    if (mem_req_we) begin
                        backing[mem_req_addr] = mem_req_wdata;
                    end
                    resp_data = backing.exists(mem_req_addr) ? backing[mem_req_addr] : 32'h0;
                    resp_due  = 1'b1;
                    resp_wait = resp_delay;
                end
            end else begin
                stall_left = ready_delay;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one MEM-stage op, counts stall cycles until data_ready_mem=1,
    // captures the load data and returns just after the retiring edge.
    task automatic applyStimulus(input logic [6:0] opcode, input logic also_read,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int stall, output logic [31:0] rdata);
        int guard;
        @(negedge clk);
        memread_mem           = (opcode == OPCODE_LOAD) || also_read;
        memwrite_mem          = (opcode == OPCODE_STORE);
        alu_result_mem        = addr;
        write_data_memory_mem = wdata;
        stall = 0;
        guard = 0;
        #1;
        while (!data_ready_mem && guard < 64) begin
            @(negedge clk);
            #1;
            stall++;
            guard++;
        end
        if (!data_ready_mem) begin
            checkOutput("ready_timeout", {31'b0, data_ready_mem}, 32'd1);
        end
        rdata = data_from_memory_mem;
        @(posedge clk);
    endtask

    initial begin
        int          stall;
        logic [31:0] rdata;
        int          req_before;

        backing[32'h0000_0100] = 32'hDEAD_BEEF;
        backing[32'h0000_0104] = 32'hCAFE_F00D;
        backing[32'h0000_0000] = 32'h0000_0011;
        backing[32'h0000_0340] = 32'h55AA_55AA;

        rstn                  = 1'b0;
        memread_mem           = 1'b0;
        memwrite_mem          = 1'b0;
        alu_result_mem        = '0;
        write_data_memory_mem = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_data_ready", {31'b0, data_ready_mem}, 32'd1);
        checkOutput("rst_req_valid",  {31'b0, mem_req_valid},  32'd0);
        checkOutput("rst_req_we",     {31'b0, mem_req_we},     32'd0);
        checkOutput("rst_req_addr",   mem_req_addr,            32'h0);
        checkOutput("rst_req_wdata",  mem_req_wdata,           32'h0);
        checkOutput("rst_rdata",      data_from_memory_mem,    32'h0);
        rstn = 1'b1;

        @(negedge clk);
        #1;
        checkOutput("noop_ready", {31'b0, data_ready_mem}, 32'd1);

        $display("[TB] cold load 0x100");
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h100, 32'h0, stall, rdata);
        checkOutput("cold_stall",   stall,          32'd3);
        checkOutput("cold_data",    rdata,          32'hDEAD_BEEF);
        checkOutput("cold_req_adr", last_req_addr,  32'h100);
        checkOutput("cold_req_we",  {31'b0, last_req_we}, 32'd0);

        $display("[TB] hits on 0x100 and 0x102");
        req_before = req_count;
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h100, 32'h0, stall, rdata);
        checkOutput("hit100_stall", stall, 32'd0);
        checkOutput("hit100_data",  rdata, 32'hDEAD_BEEF);
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h102, 32'h0, stall, rdata);
        checkOutput("hit102_stall", stall, 32'd0);
        checkOutput("hit102_data",  rdata, 32'hDEAD_BEEF);
        checkOutput("hit_no_req",   req_count - req_before, 32'd0);

        $display("[TB] store 0x200 then load 0x200");
        applyStimulus(OPCODE_STORE, 1'b0, 32'h200, 32'h1234_5678, stall, rdata);
        checkOutput("st_stall",   stall,                32'd3);
        checkOutput("st_req_we",  {31'b0, last_req_we}, 32'd1);
        checkOutput("st_req_wd",  last_req_wdata,       32'h1234_5678);
        checkOutput("st_req_adr", last_req_addr,        32'h200);
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h200, 32'h0, stall, rdata);
        checkOutput("ld200_stall", stall, 32'd0);
        checkOutput("ld200_data",  rdata, 32'h1234_5678);
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h100, 32'h0, stall, rdata);
        checkOutput("replaced_stall", stall, 32'd3);
        checkOutput("replaced_data",  rdata, 32'hDEAD_BEEF);

        $display("[TB] both strobes act as a store");
        applyStimulus(OPCODE_STORE, 1'b1, 32'h208, 32'hA5A5_A5A5, stall, rdata);
        checkOutput("both_stall", stall,                32'd3);
        checkOutput("both_we",    {31'b0, last_req_we}, 32'd1);
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h208, 32'h0, stall, rdata);
        checkOutput("both_hit", rdata, 32'hA5A5_A5A5);

        $display("[TB] slow backing: ready low for 4 cycles");
        ready_delay = 4;
        req_unstable = 1'b0;
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h104, 32'h0, stall, rdata);
        checkOutput("slow_stall",    stall,                 32'd7);
        checkOutput("slow_data",     rdata,                 32'hCAFE_F00D);
        checkOutput("slow_stable",   {31'b0, req_unstable}, 32'd0);
        ready_delay = 0;

        $display("[TB] aliasing 0x000 / 0x100");
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h000, 32'h0, stall, rdata);
        checkOutput("alias0_stall", stall, 32'd3);
        checkOutput("alias0_data",  rdata, 32'h0000_0011);
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h100, 32'h0, stall, rdata);
        checkOutput("alias1_stall", stall, 32'd3);
        checkOutput("alias1_data",  rdata, 32'hDEAD_BEEF);
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h000, 32'h0, stall, rdata);
        checkOutput("alias2_stall", stall, 32'd3);
        checkOutput("alias2_data",  rdata, 32'h0000_0011);

        applyStimulus(OPCODE_LOAD, 1'b0, 32'h100, 32'h0, stall, rdata);
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h100, 32'h0, stall, rdata);
        checkOutput("prerst_hit", stall, 32'd0);

        $display("[TB] reset while waiting for a response");
        @(negedge clk);
        resp_delay     = 3;
        memread_mem    = 1'b1;
        memwrite_mem   = 1'b0;
        alu_result_mem = 32'h340;
        @(negedge clk);
        @(negedge clk);
        rstn        = 1'b0;
        memread_mem = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midrst_ready",     {31'b0, data_ready_mem}, 32'd1);
        checkOutput("midrst_req_valid", {31'b0, mem_req_valid},  32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        resp_delay = 0;
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h100, 32'h0, stall, rdata);
        checkOutput("postrst100_stall", stall, 32'd3);
        checkOutput("postrst100_data",  rdata, 32'hDEAD_BEEF);
        applyStimulus(OPCODE_LOAD, 1'b0, 32'h340, 32'h0, stall, rdata);
        checkOutput("late_resp_stall", stall, 32'd3);
        checkOutput("late_resp_data",  rdata, 32'h55AA_55AA);

        @(negedge clk);
        memread_mem  = 1'b0;
        memwrite_mem = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule : tb_dmem_responder
